// File: rtl/blowfish128_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : blowfish128_pkg
//  Description : Shared widths, key-length limit and controller state
//                encoding for the Blowfish-128 scheduling controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package blowfish128_pkg;

  localparam int BLK_W = 128;
  localparam int KEY_W = 512;
  localparam int ST_W  = 3;

  localparam logic [3:0] KEY_LEN_MAX = 4'd8;

  typedef logic [ST_W-1:0] state_t;

  localparam logic [ST_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [ST_W-1:0] ST_KEYGEN   = 3'd1;
  localparam logic [ST_W-1:0] ST_KG_DRAIN = 3'd2;
  localparam logic [ST_W-1:0] ST_READY    = 3'd3;
  localparam logic [ST_W-1:0] ST_CORE     = 3'd4;
  localparam logic [ST_W-1:0] ST_RESP     = 3'd5;
  localparam logic [ST_W-1:0] ST_ERR      = 3'd6;

  // A key length counts 64-bit words; zero words or more than the bus holds is illegal.
  function automatic logic key_len_legal(input logic [3:0] len);
    return (len != 4'd0) && (len <= KEY_LEN_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/blowfish128_sched_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : blowfish128_sched_ctrl_if
//  Description : Host-side key-load, block-request and response channels.
//                master = host, slave = scheduling controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface blowfish128_sched_ctrl_if;
  import blowfish128_pkg::*;

  logic             key_valid;
  logic             key_ready;
  logic [KEY_W-1:0] key_in;
  logic [3:0]       key_len;
  logic             req_valid;
  logic             req_ready;
  logic             req_encrypt;
  logic [BLK_W-1:0] req_data;
  logic             resp_valid;
  logic             resp_ready;
  logic [BLK_W-1:0] resp_data;

  modport master (
    output key_valid, key_in, key_len, req_valid, req_encrypt, req_data, resp_ready,
    input  key_ready, req_ready, resp_valid, resp_data
  );

  modport slave (
    input  key_valid, key_in, key_len, req_valid, req_encrypt, req_data, resp_ready,
    output key_ready, req_ready, resp_valid, resp_data
  );

endinterface
`default_nettype wire

// File: rtl/blowfish128_sched_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : blowfish128_sched_timeout
//  Description : Clearable cycle counter. expire_o flags the enabled cycle
//                whose increment would bring the count to LIMIT.
//  Revision    : 1.0 - initial release
// ============================================================================
module blowfish128_sched_timeout #(
  parameter int LIMIT = 4096
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic clr_i,
  input  wire logic en_i,
  output logic      expire_o
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Clear has priority so a new generation run always starts from zero.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = en_i && !clr_i && (count_q == CW'(LIMIT - 1));

endmodule
`default_nettype wire

// File: rtl/blowfish128_sched_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : blowfish128_sched_ctrl
//  Description : Blowfish-128 sequencing controller. Latches the key, runs
//                the subkey generator for the cached direction, issues one
//                block at a time to the cipher core and returns the result.
//  Revision    : 1.0 - initial release
// ============================================================================
module blowfish128_sched_ctrl
  import blowfish128_pkg::*;
#(
  parameter int SKG_TIMEOUT = 4096
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  blowfish128_sched_ctrl_if.slave     bus,
  output logic                        sk_enable_o,
  output logic                        sk_encrypt_o,
  output logic [KEY_W-1:0]            sk_key_o,
  output logic [3:0]                  sk_key_length_o,
  input  wire logic                   sk_ready_i,
  output logic                        core_start_o,
  output logic                        core_encrypt_o,
  output logic [BLK_W-1:0]            core_din_o,
  input  wire logic                   core_done_i,
  input  wire logic [BLK_W-1:0]       core_dout_i,
  output logic                        sched_valid_o,
  output logic                        busy_o,
  output logic                        err_keylen_o,
  output logic                        err_timeout_o
);

  state_t           state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [3:0]       len_q, len_d;
  logic             dir_q, dir_d;
  logic             sk_en_q, sk_en_d;
  logic             sched_valid_q, sched_valid_d;
  logic             pend_q, pend_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic             start_q, start_d;
  logic             resp_valid_q, resp_valid_d;
  logic [BLK_W-1:0] resp_data_q, resp_data_d;
  logic             err_keylen_q, err_keylen_d;
  logic             err_timeout_q, err_timeout_d;

  logic key_ready_w, key_acc_w, key_legal_w;
  logic req_ready_w, req_acc_w, dir_change_w;
  logic tmo_clr_w, tmo_en_w, tmo_expire_w;

  // Key channel open only in quiescent states; key beats a simultaneous block request.
  assign key_ready_w  = !rst && ((state_q == ST_IDLE) || (state_q == ST_READY) || (state_q == ST_ERR));
  assign key_acc_w    = bus.key_valid && key_ready_w;
  assign key_legal_w  = key_len_legal(bus.key_len);
  assign req_ready_w  = !rst && (state_q == ST_READY) && !bus.key_valid;
  assign req_acc_w    = bus.req_valid && req_ready_w;
  assign dir_change_w = bus.req_encrypt != dir_q;

  // The timeout window opens whenever a generation run is started.
  assign tmo_clr_w = (key_acc_w && key_legal_w) || (req_acc_w && dir_change_w);
  assign tmo_en_w  = (state_q == ST_KEYGEN) || (state_q == ST_KG_DRAIN);

  blowfish128_sched_timeout #(
    .LIMIT (SKG_TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (tmo_clr_w),
    .en_i     (tmo_en_w),
    .expire_o (tmo_expire_w)
  );

  // Next-state and datapath-latch logic for the sequencing FSM.
  always_comb begin
    state_d       = state_q;
    key_d         = key_q;
    len_d         = len_q;
    dir_d         = dir_q;
    sk_en_d       = sk_en_q;
    sched_valid_d = sched_valid_q;
    pend_d        = pend_q;
    blk_d         = blk_q;
    start_d       = 1'b0;
    resp_valid_d  = resp_valid_q;
    resp_data_d   = resp_data_q;
    err_keylen_d  = err_keylen_q;
    err_timeout_d = err_timeout_q;

    case (state_q)
      ST_IDLE, ST_READY, ST_ERR: begin
        if (key_acc_w) begin
          sched_valid_d = 1'b0;
          pend_d        = 1'b0;
          if (key_legal_w) begin
            key_d         = bus.key_in;
            len_d         = bus.key_len;
            dir_d         = 1'b1;
            err_keylen_d  = 1'b0;
            err_timeout_d = 1'b0;
            // The generator must be seen idle before Enable is raised.
            if (sk_ready_i) begin
              state_d = ST_KG_DRAIN;
              sk_en_d = 1'b0;
            end else begin
              state_d = ST_KEYGEN;
              sk_en_d = 1'b1;
            end
          end else begin
            err_keylen_d = 1'b1;
            state_d      = ST_IDLE;
          end
        end else if (req_acc_w) begin
          blk_d = bus.req_data;
          if (dir_change_w) begin
            // P-array is for the other direction: regenerate, keep the block pending.
            dir_d         = bus.req_encrypt;
            sched_valid_d = 1'b0;
            pend_d        = 1'b1;
            if (sk_ready_i) begin
              state_d = ST_KG_DRAIN;
              sk_en_d = 1'b0;
            end else begin
              state_d = ST_KEYGEN;
              sk_en_d = 1'b1;
            end
          end else begin
            state_d = ST_CORE;
            start_d = 1'b1;
          end
        end
      end

      ST_KG_DRAIN: begin
        if (tmo_expire_w) begin
          state_d       = ST_ERR;
          err_timeout_d = 1'b1;
          sk_en_d       = 1'b0;
        end else if (!sk_ready_i) begin
          state_d = ST_KEYGEN;
          sk_en_d = 1'b1;
        end
      end

      ST_KEYGEN: begin
        if (sk_ready_i) begin
          sk_en_d       = 1'b0;
          sched_valid_d = 1'b1;
          if (pend_q) begin
            pend_d  = 1'b0;
            state_d = ST_CORE;
            start_d = 1'b1;
          end else begin
            state_d = ST_READY;
          end
        end else if (tmo_expire_w) begin
          state_d       = ST_ERR;
          err_timeout_d = 1'b1;
          sk_en_d       = 1'b0;
        end
      end

      ST_CORE: begin
        if (core_done_i) begin
          resp_data_d  = core_dout_i;
          resp_valid_d = 1'b1;
          state_d      = ST_RESP;
        end
      end

      ST_RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ST_READY;
        end
      end

      default: begin
        state_d = ST_IDLE;
        sk_en_d = 1'b0;
      end
    endcase
  end

  // State and latch registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      key_q         <= '0;
      len_q         <= '0;
      dir_q         <= 1'b0;
      sk_en_q       <= 1'b0;
      sched_valid_q <= 1'b0;
      pend_q        <= 1'b0;
      blk_q         <= '0;
      start_q       <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
      err_keylen_q  <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      key_q         <= key_d;
      len_q         <= len_d;
      dir_q         <= dir_d;
      sk_en_q       <= sk_en_d;
      sched_valid_q <= sched_valid_d;
      pend_q        <= pend_d;
      blk_q         <= blk_d;
      start_q       <= start_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
      err_keylen_q  <= err_keylen_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign bus.key_ready  = key_ready_w;
  assign bus.req_ready  = req_ready_w;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;

  assign sk_enable_o     = sk_en_q;
  assign sk_encrypt_o    = dir_q;
  assign sk_key_o        = key_q;
  assign sk_key_length_o = len_q;
  assign core_start_o    = start_q;
  assign core_encrypt_o  = dir_q;
  assign core_din_o      = blk_q;
  assign sched_valid_o   = sched_valid_q;
  assign busy_o          = (state_q != ST_IDLE) && (state_q != ST_READY);
  assign err_keylen_o    = err_keylen_q;
  assign err_timeout_o   = err_timeout_q;

endmodule
`default_nettype wire
